// File: rtl/regwrite_queue.sv
// regwrite_queue: in-order write queue in front of the register file.
//
// Results pushed by execute/retire are buffered in a circular queue and drained
// one per cycle onto a registered global-file write port (gw_*) or local-file write
// port (lw_*), selected by each entry's local bit. A combinational lookup port reports
// whether a register still has a write in flight and returns the youngest value.
//
// Optional feature (compile-time macro REGWQ_DUAL_DRAIN_EN): when the two oldest
// entries target different files, both drain in the same cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     push handshake; in_local/in_addr/in_data carry the write
//   flush                 discard every queued entry (loaded port writes still complete)
//   gw_en/gw_addr/gw_data registered global-file write port
//   lw_en/lw_addr/lw_data registered local-file write port
//   chk_local/chk_addr    lookup key; chk_hit/chk_data report the youngest pending write
//   count                 number of occupied queue entries
module regwrite_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_local,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    input  logic                   flush,
    output logic                   gw_en,
    output logic [AW-1:0]          gw_addr,
    output logic [DW-1:0]          gw_data,
    output logic                   lw_en,
    output logic [AW-1:0]          lw_addr,
    output logic [DW-1:0]          lw_data,
    input  logic                   chk_local,
    input  logic [AW-1:0]          chk_addr,
    output logic                   chk_hit,
    output logic [DW-1:0]          chk_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Queue storage (no reset needed: occupancy is tracked by count_q)
    logic          ent_local_q [DEPTH];
    logic [AW-1:0] ent_addr_q  [DEPTH];
    logic [DW-1:0] ent_data_q  [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          pop_one;
    logic          pop_two;
    logic [1:0]    n_pop;

    logic          gw_load, lw_load;
    logic [AW-1:0] gw_addr_d, lw_addr_d;
    logic [DW-1:0] gw_data_d, lw_data_d;

    // A same-cycle pop never frees a slot for a push: a full queue refuses.
    assign in_ready = (count_q < CW'(DEPTH));
    // Flush wins over push: the pushed entry is dropped.
    assign push     = in_valid & in_ready & ~flush;
    assign head_nxt = head_q + PW'(1);
    assign count    = count_q;

    // Issue selection. Flush suppresses issue so that nothing queued reaches a port.
    always_comb begin
        pop_one = 1'b0;
        pop_two = 1'b0;
        if (!flush && (count_q != '0)) begin
            pop_one = 1'b1;
`ifdef REGWQ_DUAL_DRAIN_EN
            if ((count_q >= CW'(2)) && (ent_local_q[head_nxt] != ent_local_q[head_q])) begin
                pop_two = 1'b1;
            end
`endif
        end
    end

    // 0, 1 or 2 entries leave the queue
    assign n_pop = {pop_two, pop_one & ~pop_two};

    // Port register loading; unloaded ports keep addr/data and drop en.
    always_comb begin
        gw_load   = 1'b0;
        lw_load   = 1'b0;
        gw_addr_d = gw_addr;
        gw_data_d = gw_data;
        lw_addr_d = lw_addr;
        lw_data_d = lw_data;
        if (pop_one) begin
            if (ent_local_q[head_q]) begin
                lw_load   = 1'b1;
                lw_addr_d = ent_addr_q[head_q];
                lw_data_d = ent_data_q[head_q];
            end else begin
                gw_load   = 1'b1;
                gw_addr_d = ent_addr_q[head_q];
                gw_data_d = ent_data_q[head_q];
            end
        end
        // pop_two only when head+1 targets the other file, so no port conflict
        if (pop_two) begin
            if (ent_local_q[head_nxt]) begin
                lw_load   = 1'b1;
                lw_addr_d = ent_addr_q[head_nxt];
                lw_data_d = ent_data_q[head_nxt];
            end else begin
                gw_load   = 1'b1;
                gw_addr_d = ent_addr_q[head_nxt];
                gw_data_d = ent_data_q[head_nxt];
            end
        end
    end

    // Pointer and occupancy next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(n_pop);
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(n_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            gw_en   <= 1'b0;
            gw_addr <= '0;
            gw_data <= '0;
            lw_en   <= 1'b0;
            lw_addr <= '0;
            lw_data <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            gw_en   <= gw_load;
            gw_addr <= gw_addr_d;
            gw_data <= gw_data_d;
            lw_en   <= lw_load;
            lw_addr <= lw_addr_d;
            lw_data <= lw_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_local_q[tail_q] <= in_local;
            ent_addr_q[tail_q]  <= in_addr;
            ent_data_q[tail_q]  <= in_data;
        end
    end

    // Lookup: scan oldest to youngest so the youngest queue match wins; the port
    // registers hold older writes, so they are consulted only without a queue match.
    always_comb begin
        logic          q_hit;
        logic [DW-1:0] q_data;
        logic [PW-1:0] idx;
        q_hit    = 1'b0;
        q_data   = '0;
        idx      = head_q;
        chk_hit  = 1'b0;
        chk_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (ent_local_q[idx] == chk_local) &&
                (ent_addr_q[idx] == chk_addr)) begin
                q_hit  = 1'b1;
                q_data = ent_data_q[idx];
            end
        end
        if (q_hit) begin
            chk_hit  = 1'b1;
            chk_data = q_data;
        end else if (chk_local && lw_en && (lw_addr == chk_addr)) begin
            chk_hit  = 1'b1;
            chk_data = lw_data;
        end else if (!chk_local && gw_en && (gw_addr == chk_addr)) begin
            chk_hit  = 1'b1;
            chk_data = gw_data;
        end
    end

endmodule

// File: tb/tb_regwrite_queue.sv
module tb_regwrite_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_local, flush;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          gw_en, lw_en;
    logic [AW-1:0] gw_addr, lw_addr;
    logic [DW-1:0] gw_data, lw_data;
    logic          chk_local, chk_hit;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] chk_data;
    logic [CW-1:0] count;

    regwrite_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_local  (in_local),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .flush     (flush),
        .gw_en     (gw_en),
        .gw_addr   (gw_addr),
        .gw_data   (gw_data),
        .lw_en     (lw_en),
        .lw_addr   (lw_addr),
        .lw_data   (lw_data),
        .chk_local (chk_local),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .chk_data  (chk_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          loc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          fl;
        logic          cl;
        logic [AW-1:0] ca;
        logic          tbl;    // hand-computed expectations below are valid
        int unsigned   cnt;
        logic          hit;
        logic [DW-1:0] cdata;
        logic          gwe;
        logic          lwe;
    } vec_t;

    typedef struct {
        logic          loc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model: queue contents, port registers, per-port scoreboards
    ent_t          mq[$];
    ent_t          exp_g[$];
    ent_t          exp_l[$];
    logic          mg_en, ml_en;
    logic [AW-1:0] mg_addr, ml_addr;
    logic [DW-1:0] mg_data, ml_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_g.delete();
        exp_l.delete();
        mg_en = 1'b0; mg_addr = '0; mg_data = '0;
        ml_en = 1'b0; ml_addr = '0; ml_data = '0;
    endtask

    task automatic load_port(input ent_t e);
        if (e.loc) begin
            ml_en = 1'b1; ml_addr = e.addr; ml_data = e.data;
        end else begin
            mg_en = 1'b1; mg_addr = e.addr; mg_data = e.data;
        end
    endtask

    function automatic vec_t mk(input logic v, input logic loc, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic fl, input logic cl,
                                input logic [AW-1:0] ca, input int unsigned cnt,
                                input logic hit, input logic [DW-1:0] cdata,
                                input logic gwe, input logic lwe);
        vec_t t;
        t.v = v; t.loc = loc; t.addr = addr; t.data = data; t.fl = fl;
        t.cl = cl; t.ca = ca; t.tbl = 1'b1; t.cnt = cnt; t.hit = hit;
        t.cdata = cdata; t.gwe = gwe; t.lwe = lwe;
        return t;
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge, leaves the same way.
    task automatic run(input vec_t t);
        ent_t          e, tmp;
        logic          hit, acc;
        logic [DW-1:0] hd;
        in_valid  = t.v;
        in_local  = t.loc;
        in_addr   = t.addr;
        in_data   = t.data;
        flush     = t.fl;
        chk_local = t.cl;
        chk_addr  = t.ca;
        #1;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("count", count, mq.size());
        chk("gw_en", gw_en, mg_en);
        chk("lw_en", lw_en, ml_en);
        chk("gw_addr", gw_addr, mg_addr);
        chk("gw_data", gw_data, mg_data);
        chk("lw_addr", lw_addr, ml_addr);
        chk("lw_data", lw_data, ml_data);
        if (gw_en === 1'b1) begin
            if (exp_g.size() == 0) begin
                chk("gw_unexpected_write", 1, 0);
            end else begin
                tmp = exp_g.pop_front();
                chk("gw_order_addr", gw_addr, tmp.addr);
                chk("gw_order_data", gw_data, tmp.data);
            end
        end
        if (lw_en === 1'b1) begin
            if (exp_l.size() == 0) begin
                chk("lw_unexpected_write", 1, 0);
            end else begin
                tmp = exp_l.pop_front();
                chk("lw_order_addr", lw_addr, tmp.addr);
                chk("lw_order_data", lw_data, tmp.data);
            end
        end
        hit = 1'b0;
        hd  = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i].loc == t.cl && mq[i].addr == t.ca) begin
                hit = 1'b1;
                hd  = mq[i].data;
            end
        end
        if (!hit && t.cl && ml_en && ml_addr == t.ca) begin
            hit = 1'b1; hd = ml_data;
        end else if (!hit && !t.cl && mg_en && mg_addr == t.ca) begin
            hit = 1'b1; hd = mg_data;
        end
        chk("chk_hit", chk_hit, hit);
        chk("chk_data", chk_data, hd);
        if (t.tbl) begin
            chk("tbl_count", count, t.cnt);
            chk("tbl_chk_hit", chk_hit, t.hit);
            chk("tbl_chk_data", chk_data, t.cdata);
            chk("tbl_gw_en", gw_en, t.gwe);
            chk("tbl_lw_en", lw_en, t.lwe);
        end
        // Advance the model
        acc   = t.v && !t.fl && (mq.size() < DEPTH);
        mg_en = 1'b0;
        ml_en = 1'b0;
        if (t.fl) begin
            while (mq.size() > 0) begin
                e = mq.pop_back();
                if (e.loc) tmp = exp_l.pop_back();
                else       tmp = exp_g.pop_back();
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            load_port(e);
`ifdef REGWQ_DUAL_DRAIN_EN
            if (mq.size() > 0 && mq[0].loc != e.loc) begin
                e = mq.pop_front();
                load_port(e);
            end
`endif
        end
        if (acc) begin
            e.loc = t.loc; e.addr = t.addr; e.data = t.data;
            mq.push_back(e);
            if (t.loc) exp_l.push_back(e);
            else       exp_g.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    function automatic vec_t idle(input logic cl, input logic [AW-1:0] ca);
        vec_t t;
        t = mk(1'b0, 1'b0, '0, '0, 1'b0, cl, ca, 0, 1'b0, '0, 1'b0, 1'b0);
        t.tbl = 1'b0;
        return t;
    endfunction

    initial begin
        vec_t t;
        //             v  loc addr   data    fl cl ca     cnt hit cdata   gwe lwe
        tbl[0]  = mk(1, 0, 8'h20, 64'h1111, 0, 0, 8'h20, 0, 0, 64'h0,    0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h20, 1, 1, 64'h1111, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h20, 0, 1, 64'h1111, 1, 0);
        tbl[3]  = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h20, 0, 0, 64'h0,    0, 0);
        tbl[4]  = mk(1, 1, 8'h05, 64'hA,    0, 1, 8'h05, 0, 0, 64'h0,    0, 0);
        tbl[5]  = mk(1, 1, 8'h05, 64'hB,    0, 1, 8'h05, 1, 1, 64'hA,    0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 64'h0,    0, 1, 8'h05, 1, 1, 64'hB,    0, 1);
        tbl[7]  = mk(0, 0, 8'h00, 64'h0,    0, 1, 8'h05, 0, 1, 64'hB,    0, 1);
        tbl[8]  = mk(0, 0, 8'h00, 64'h0,    0, 1, 8'h05, 0, 0, 64'h0,    0, 0);
        tbl[9]  = mk(1, 0, 8'h10, 64'hD1,   0, 0, 8'h10, 0, 0, 64'h0,    0, 0);
        tbl[10] = mk(1, 1, 8'h11, 64'hD2,   0, 0, 8'h10, 1, 1, 64'hD1,   0, 0);
        tbl[11] = mk(1, 0, 8'h12, 64'hD3,   0, 0, 8'h10, 1, 1, 64'hD1,   1, 0);
        tbl[12] = mk(1, 1, 8'h13, 64'hD4,   0, 0, 8'h10, 1, 0, 64'h0,    0, 1);
        tbl[13] = mk(1, 0, 8'h10, 64'hD5,   0, 0, 8'h10, 1, 0, 64'h0,    1, 0);
        tbl[14] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h10, 1, 1, 64'hD5,   0, 1);
        tbl[15] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h10, 0, 1, 64'hD5,   1, 0);
        tbl[16] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h10, 0, 0, 64'h0,    0, 0);
        tbl[17] = mk(1, 0, 8'h30, 64'hAA,   0, 0, 8'h31, 0, 0, 64'h0,    0, 0);
        tbl[18] = mk(1, 0, 8'h31, 64'hBB,   0, 0, 8'h31, 1, 0, 64'h0,    0, 0);
        tbl[19] = mk(1, 0, 8'h32, 64'hCC,   1, 0, 8'h31, 1, 1, 64'hBB,   1, 0);
        tbl[20] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h31, 0, 0, 64'h0,    0, 0);
        tbl[21] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h32, 0, 0, 64'h0,    0, 0);
        tbl[22] = mk(0, 0, 8'h00, 64'h0,    0, 0, 8'h30, 0, 0, 64'h0,    0, 0);

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_local  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        flush     = 1'b0;
        chk_local = 1'b0;
        chk_addr  = '0;
        model_reset();

        #2;
        chk("rst_gw_en", gw_en, 0);
        chk("rst_lw_en", lw_en, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_gw_addr", gw_addr, 0);
        chk("rst_gw_data", gw_data, 0);
        chk("rst_lw_addr", lw_addr, 0);
        chk("rst_lw_data", lw_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            run(tbl[i]);
        end

        // Reset while a global write is on the port and an entry is queued
        t = idle(1'b0, 8'h40);
        t.v = 1'b1; t.loc = 1'b0; t.addr = 8'h40; t.data = 64'h5;
        run(t);
        t = idle(1'b0, 8'h40);
        t.v = 1'b1; t.loc = 1'b1; t.addr = 8'h41; t.data = 64'h6;
        run(t);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_gw_en", gw_en, 1);
        chk("pre_rst_count", count, 1);
        chk("pre_rst_gw_addr", gw_addr, 64'h40);
        reset_n = 1'b0;
        #1;
        chk("async_rst_gw_en", gw_en, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_lw_en", lw_en, 0);
        chk("async_rst_gw_addr", gw_addr, 0);
        chk("async_rst_gw_data", gw_data, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("held_rst_lw_en", lw_en, 0);
        chk("held_rst_count", count, 0);
        reset_n = 1'b1;
        model_reset();

        // Queue works again after reset; the lost local entry never shows up
        t = idle(1'b1, 8'h41);
        t.v = 1'b1; t.loc = 1'b1; t.addr = 8'h50; t.data = 64'h77;
        run(t);
        for (int i = 0; i < 4; i++) begin
            run(idle(1'b1, 8'h50));
        end

        chk("scoreboard_drained", exp_g.size() + exp_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
